// File: rtl/dll_lock_supervisor_pkg.sv
// Shared types for the DLL lock supervisor: per-channel FSM state encoding
// and the retry counter width.
package dll_lock_supervisor_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAULT     = 3'd4
    } dll_state_t;

    function automatic logic drives_dll_rst(input dll_state_t st);
        return (st == ST_RESET) || (st == ST_FAULT);
    endfunction

endpackage

// File: rtl/dll_lock_supervisor_chan.sv
// One supervised DLL channel: LOCKED synchronizer, reset/lock sequencing FSM,
// in-state cycle counter, retry counter and registered board-facing outputs.
//
// state        | meaning
// ST_RESET     | dll_rst held high for RST_PULSE cycles (or indefinitely while disabled)
// ST_WAIT_LOCK | dll_rst released, waiting up to LOCK_TIMEOUT cycles for lock_s
// ST_STABLE    | lock_s seen, must stay high for STABLE_CYCLES cycles
// ST_LOCKED    | qualified lock, locked_n driven low
// ST_FAULT     | MAX_RETRY attempts failed, DLL held in reset until clear_fault
module dll_lock_supervisor_chan
    import dll_lock_supervisor_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int RST_PULSE     = 4,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic chan_en,
    input  logic clear_fault,
    input  logic dll_locked,
    output logic dll_rst,
    output logic locked_n,
    output logic fault,
    output logic lost_lock
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    logic [1:0]         sync_q;
    logic               lock_s;
    dll_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               lost_d;

    assign lock_s    = sync_q[1];
    assign retry_inc = retry_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        lost_d  = lost_lock;

        if (!chan_en) begin
            // Disable wins over everything; retry history survives the disable.
            state_d = ST_RESET;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET;
                        cnt_d   = '0;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                ST_LOCKED: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RESET;
                        lost_d  = 1'b1;
                    end
                end
                ST_FAULT: begin
                    cnt_d = '0;
                    if (clear_fault) begin
                        state_d = ST_RESET;
                        retry_d = '0;
                        lost_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            dll_rst   <= 1'b1;
            locked_n  <= 1'b1;
            fault     <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], dll_locked};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dll_rst   <= drives_dll_rst(state_d);
            locked_n  <= (state_d != ST_LOCKED);
            fault     <= (state_d == ST_FAULT);
            lost_lock <= lost_d;
        end
    end

endmodule

// File: rtl/dll_lock_supervisor.sv
// NUM_DLL-channel DLL reset/lock supervisor: one sequencer per DLL plus a
// registered aggregate lock indication over the enabled channels.
module dll_lock_supervisor
    import dll_lock_supervisor_pkg::*;
#(
    parameter int NUM_DLL       = 2,
    parameter int CNT_W         = 16,
    parameter int RST_PULSE     = 4,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DLL-1:0] chan_en,
    input  logic [NUM_DLL-1:0] clear_fault,
    input  logic [NUM_DLL-1:0] dll_locked,
    output logic [NUM_DLL-1:0] dll_rst,
    output logic [NUM_DLL-1:0] locked_n,
    output logic [NUM_DLL-1:0] fault,
    output logic [NUM_DLL-1:0] lost_lock,
    output logic               all_locked
);

    for (genvar i = 0; i < NUM_DLL; i++) begin : g_chan
        dll_lock_supervisor_chan #(
            .CNT_W         (CNT_W),
            .RST_PULSE     (RST_PULSE),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT),
            .STABLE_CYCLES (STABLE_CYCLES),
            .MAX_RETRY     (MAX_RETRY)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .chan_en     (chan_en[i]),
            .clear_fault (clear_fault[i]),
            .dll_locked  (dll_locked[i]),
            .dll_rst     (dll_rst[i]),
            .locked_n    (locked_n[i]),
            .fault       (fault[i]),
            .lost_lock   (lost_lock[i])
        );
    end

    // Disabled channels are don't-care, but at least one must be enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= (&(~chan_en | ~locked_n)) & (|chan_en);
        end
    end

endmodule
